// File: rtl/cache_pkg.sv
// cache_pkg: FSM encoding, request field layout and derived widths
// shared by the set-associative byte cache and its way arrays.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT,
        RESPOND,
        RELEASE
    } state_t;

    // Request layout is {we, wdata[7:0], addr}: addr from bit 0 upward,
    // wdata directly above it, we in the top bit.
    function automatic int req_w(input int addr_w);
        return addr_w + 9;
    endfunction

    function automatic int wdata_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int we_bit(input int addr_w);
        return addr_w + 8;
    endfunction

    function automatic int offset_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes,
                                 input int sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

    // A single way still needs a 1-bit victim pointer.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: one way of the cache (valid/tag/data per set).
// Ports: index/tag lookup -> hit, line_valid, line; fill/fill_line/fill_dead
// install at index; inv/inv_index/inv_tag snoop-clear of a matching line.
module cache_way_array #(
    parameter int SETS    = 8,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 12,
    parameter int LINE_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic               line_valid,
    output logic [LINE_W-1:0]  line,
    input  logic               fill,
    input  logic [LINE_W-1:0]  fill_line,
    input  logic               fill_dead,
    input  logic               inv,
    input  logic [INDEX_W-1:0] inv_index,
    input  logic [TAG_W-1:0]   inv_tag
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [LINE_W-1:0] data [SETS];
    logic              inv_hit;

    assign line_valid = valid[index];
    assign line       = data[index];
    assign hit        = valid[index] && (tags[index] == tag);
    assign inv_hit    = inv && valid[inv_index] && (tags[inv_index] == inv_tag);

    // A fill to the same set overrides a snoop that hit the evicted line;
    // a snoop of the incoming line itself arrives as fill_dead.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (inv_hit) valid[inv_index] <= 1'b0;
            if (fill)    valid[index]     <= !fill_dead;
        end
    end

    always_ff @(posedge clock) begin
        if (fill) begin
            tags[index] <= tag;
            data[index] <= fill_line;
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-through, write-allocate byte cache.
// Ports: cpu_request/_ready in, data_out/_ready out, memory_request/_ready out,
// memory_response/_ready in, invalidate_address/_valid snoop in.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LINE_BYTES = 2,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W+8:0]       cpu_request,
    input  logic                    cpu_request_ready,
    input  logic [ADDR_W-1:0]       invalidate_address,
    input  logic                    invalidate_valid,
    output logic [ADDR_W+8:0]       memory_request,
    output logic                    memory_request_ready,
    input  logic [LINE_BYTES*8-1:0] memory_response,
    input  logic                    memory_response_ready,
    output logic [7:0]              data_out,
    output logic                    data_out_ready
);

    localparam int OFFSET_W = offset_w(LINE_BYTES);
    localparam int INDEX_W  = index_w(SETS);
    localparam int TAG_W    = tag_w(ADDR_W, LINE_BYTES, SETS);
    localparam int WAY_W    = way_w(WAYS);
    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int WE_BIT   = we_bit(ADDR_W);

    state_t            state;
    logic [ADDR_W+8:0] req;
    logic [WAY_W-1:0]  victim [SETS];

    logic                req_we;
    logic [OFFSET_W-1:0] req_offset;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  inv_index;
    logic [TAG_W-1:0]    inv_tag;
    logic                inv_offset_unused;
    logic                inv_req;

    assign req_we     = req[WE_BIT];
    assign req_offset = req[OFFSET_W-1:0];
    assign req_index  = req[OFFSET_W +: INDEX_W];
    assign req_tag    = req[ADDR_W-1 -: TAG_W];
    assign inv_index  = invalidate_address[OFFSET_W +: INDEX_W];
    assign inv_tag    = invalidate_address[ADDR_W-1 -: TAG_W];
    assign inv_offset_unused = ^invalidate_address[OFFSET_W-1:0];

    // Snoop aimed at the line the held request is working on.
    assign inv_req = invalidate_valid
                  && (inv_index == req_index)
                  && (inv_tag == req_tag);

    logic [WAYS-1:0]   hit;
    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   fill;
    logic [LINE_W-1:0] way_line [WAYS];

    logic              any_hit;
    logic              any_free;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  fill_way;
    logic [LINE_W-1:0] hit_line;
    logic              fill_now;
    logic [WAY_W-1:0]  victim_next;

    // Descending scan so the lowest-numbered free way wins.
    always_comb begin
        any_hit  = 1'b0;
        any_free = 1'b0;
        hit_way  = '0;
        free_way = '0;
        hit_line = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w]) begin
                any_hit  = 1'b1;
                hit_way  = WAY_W'(w);
                hit_line = way_line[w];
            end
            if (!way_valid[w]) begin
                any_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        if (any_hit)       fill_way = hit_way;
        else if (any_free) fill_way = free_way;
        else               fill_way = victim[req_index];
    end

    assign fill_now    = (state == MEM_WAIT) && memory_response_ready;
    assign victim_next = (victim[req_index] == WAY_W'(WAYS - 1))
                       ? '0 : victim[req_index] + WAY_W'(1);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign fill[w] = fill_now && (fill_way == WAY_W'(w));

        cache_way_array #(
            .SETS   (SETS),
            .INDEX_W(INDEX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clock     (clock),
            .reset     (reset),
            .index     (req_index),
            .tag       (req_tag),
            .hit       (hit[w]),
            .line_valid(way_valid[w]),
            .line      (way_line[w]),
            .fill      (fill[w]),
            .fill_line (memory_response),
            .fill_dead (inv_req),
            .inv       (invalidate_valid),
            .inv_index (inv_index),
            .inv_tag   (inv_tag)
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            req                  <= '0;
            memory_request       <= '0;
            memory_request_ready <= 1'b0;
            data_out             <= '0;
            data_out_ready       <= 1'b0;
            for (int s = 0; s < SETS; s++) victim[s] <= '0;
        end else begin
            data_out_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_request_ready) begin
                        req   <= cpu_request;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!req_we && any_hit && !inv_req) begin
                        data_out       <= hit_line[{req_offset, 3'b000} +: 8];
                        data_out_ready <= 1'b1;
                        state          <= RESPOND;
                    end else begin
                        memory_request       <= req;
                        memory_request_ready <= 1'b1;
                        state                <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (memory_response_ready) begin
                        data_out <= memory_response[{req_offset, 3'b000} +: 8];
                        data_out_ready       <= 1'b1;
                        memory_request_ready <= 1'b0;
                        state                <= RESPOND;
                        // Only evicting a valid line rotates the victim.
                        if (!any_hit && !any_free)
                            victim[req_index] <= victim_next;
                    end
                end
                RESPOND: begin
                    memory_request_ready <= 1'b0;
                    state                <= RELEASE;
                end
                RELEASE: begin
                    if (!cpu_request_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: table-driven and randomized checks of assoc_cache
// against a memory model and a per-set way/tag reference model.
module tb_assoc_cache;

    localparam int ADDR_W = 16;
    localparam int LB     = 2;
    localparam int NS     = 8;
    localparam int NW     = 2;
    localparam int OFF_W  = 1;
    localparam int IDX_W  = 3;

    logic                clock = 1'b0;
    logic                reset;
    logic [ADDR_W+8:0]   cpu_request;
    logic                cpu_request_ready;
    logic [ADDR_W-1:0]   invalidate_address;
    logic                invalidate_valid;
    logic [ADDR_W+8:0]   memory_request;
    logic                memory_request_ready;
    logic [LB*8-1:0]     memory_response;
    logic                memory_response_ready;
    logic [7:0]          data_out;
    logic                data_out_ready;

    always #5 clock = ~clock;

    assoc_cache #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LB), .SETS(NS), .WAYS(NW)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .cpu_request          (cpu_request),
        .cpu_request_ready    (cpu_request_ready),
        .invalidate_address   (invalidate_address),
        .invalidate_valid     (invalidate_valid),
        .memory_request       (memory_request),
        .memory_request_ready (memory_request_ready),
        .memory_response      (memory_response),
        .memory_response_ready(memory_response_ready),
        .data_out             (data_out),
        .data_out_ready       (data_out_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [65536];
    bit         m_valid  [NS][NW];
    int         m_tag    [NS][NW];
    int         m_victim [NS];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int set_of(input int a);
        return (a >> OFF_W) % NS;
    endfunction

    function automatic int tag_of(input int a);
        return a >> (OFF_W + IDX_W);
    endfunction

    function automatic bit m_hit(input int a);
        bit h = 0;
        for (int w = 0; w < NW; w++)
            if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) h = 1;
        return h;
    endfunction

    task automatic m_inv(input int a);
        for (int w = 0; w < NW; w++)
            if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a))
                m_valid[set_of(a)][w] = 0;
    endtask

    task automatic m_reset();
        for (int s = 0; s < NS; s++) begin
            m_victim[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
        end
    endtask

    // Install rule: matching way, else first empty way, else the set's
    // round-robin victim (which only moves when a live line is evicted).
    task automatic m_fill(input int a, input bit kill, input int ka);
        int s = set_of(a);
        int t = tag_of(a);
        int way = -1;
        for (int w = 0; w < NW; w++)
            if (way < 0 && m_valid[s][w] && m_tag[s][w] == t) way = w;
        for (int w = 0; w < NW; w++)
            if (way < 0 && !m_valid[s][w]) way = w;
        if (way < 0) begin
            way = m_victim[s];
            m_victim[s] = (m_victim[s] + 1) % NW;
        end
        if (kill) m_inv(ka);
        m_valid[s][way] = !(kill && set_of(ka) == s && tag_of(ka) == t);
        m_tag[s][way] = t;
    endtask

    task automatic pulse_inv(input logic [15:0] a);
        invalidate_address = a;
        invalidate_valid = 1'b1;
        @(posedge clock); #1;
        invalidate_valid = 1'b0;
        m_inv(a);
    endtask

    task automatic access(input bit we, input logic [7:0] wd,
                          input logic [15:0] a, input bit kill,
                          input logic [15:0] ka, input int hold,
                          output logic [7:0] rd, output bit used);
        logic [7:0]  exp_d;
        logic [15:0] base;
        bit exp_used, got;
        int lat, delay, wcnt, extra;
        exp_used = we || !m_hit(a);
        exp_d = we ? wd : mem[a];
        base = a & 16'hFFFE;
        delay = $urandom_range(0, 2);
        wcnt = 0; lat = 0; got = 0; used = 0; rd = '0; extra = 0;
        cpu_request = {we, wd, a};
        cpu_request_ready = 1'b1;
        while (!got && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            memory_response_ready = 1'b0;
            invalidate_valid = 1'b0;
            if (data_out_ready) begin
                got = 1;
                rd = data_out;
            end else if (memory_request_ready) begin
                if (!used) check("mem_req", memory_request, {we, wd, a});
                else       check("mem_req_hold", memory_request, {we, wd, a});
                used = 1;
                if (wcnt == delay) begin
                    if (we) mem[a] = wd;
                    memory_response = {mem[base + 16'd1], mem[base]};
                    memory_response_ready = 1'b1;
                    if (kill) begin
                        invalidate_address = ka;
                        invalidate_valid = 1'b1;
                    end
                end
                wcnt++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: no data_out_ready for addr %0h", a);
        end
        check("data", rd, exp_d);
        check("mem_used", used, exp_used);
        check("latency", lat, exp_used ? 3 + delay : 2);
        repeat (hold) begin
            @(posedge clock); #1;
            if (data_out_ready || memory_request_ready) extra++;
        end
        cpu_request_ready = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
            if (data_out_ready || memory_request_ready) extra++;
        end
        check("single_pulse", extra, 0);
        if (exp_used && got) m_fill(a, kill, ka);
    endtask

    typedef struct {
        bit         we;
        logic [7:0] wd;
        logic [15:0] addr;
        logic [7:0] exp;
        bit         exp_mem;
    } vec_t;

    vec_t        vecs [15];
    logic [7:0]  rd;
    bit          used;
    bit          seen;
    int          extra;
    logic [15:0] ra, ka;

    initial begin
        vecs = '{
            '{1'b1, 8'h55, 16'h0012, 8'h55, 1'b1},
            '{1'b1, 8'h56, 16'h0013, 8'h56, 1'b1},
            '{1'b0, 8'h00, 16'h0012, 8'h55, 1'b0},
            '{1'b0, 8'h00, 16'h0013, 8'h56, 1'b0},
            '{1'b1, 8'h34, 16'h0013, 8'h34, 1'b1},
            '{1'b0, 8'h00, 16'h0013, 8'h34, 1'b0},
            '{1'b1, 8'h21, 16'h0012, 8'h21, 1'b1},
            '{1'b0, 8'h00, 16'h0012, 8'h21, 1'b0},
            '{1'b0, 8'h00, 16'h0013, 8'h34, 1'b0},
            '{1'b0, 8'h00, 16'h0012, 8'h21, 1'b0},
            '{1'b0, 8'h00, 16'h0010, 8'h4A, 1'b1},
            '{1'b0, 8'h00, 16'h0110, 8'h4B, 1'b1},
            '{1'b0, 8'h00, 16'h0210, 8'h48, 1'b1},
            '{1'b0, 8'h00, 16'h0010, 8'h4A, 1'b1},
            '{1'b0, 8'h00, 16'h0210, 8'h48, 1'b0}
        };
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        m_reset();

        reset = 1'b1;
        cpu_request = '0;
        cpu_request_ready = 1'b0;
        invalidate_address = '0;
        invalidate_valid = 1'b0;
        memory_response = '0;
        memory_response_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_mrr", memory_request_ready, 0);
        check("rst_mreq", memory_request, 0);
        check("rst_dout", data_out, 0);
        check("rst_dor", data_out_ready, 0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].we, vecs[i].wd, vecs[i].addr, 1'b0, 16'h0,
                   (i == 2) ? 5 : 0, rd, used);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
            check($sformatf("vec%0d_mem", i), used, vecs[i].exp_mem);
        end

        access(1'b0, 8'h00, 16'h0012, 1'b0, 16'h0, 0, rd, used);
        check("t4_hit", used, 0);
        pulse_inv(16'h0013);
        access(1'b0, 8'h00, 16'h0012, 1'b0, 16'h0, 0, rd, used);
        check("t4_miss", used, 1);
        check("t4_data", rd, 8'h21);

        access(1'b0, 8'h00, 16'h0020, 1'b1, 16'h0020, 0, rd, used);
        check("t5_data", rd, 8'h7A);
        access(1'b0, 8'h00, 16'h0020, 1'b0, 16'h0, 0, rd, used);
        check("t5_miss", used, 1);

        cpu_request = {1'b0, 8'h00, 16'h0400};
        cpu_request_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clock); #1;
            seen = memory_request_ready;
        end
        check("t6_mrr_seen", seen, 1);
        reset = 1'b1;
        cpu_request_ready = 1'b0;
        @(posedge clock); #1;
        check("t6_mrr_cleared", memory_request_ready, 0);
        check("t6_no_data", data_out_ready, 0);
        reset = 1'b0;
        memory_response = 16'hBEEF;
        memory_response_ready = 1'b1;
        extra = 0;
        repeat (3) begin
            @(posedge clock); #1;
            memory_response_ready = 1'b0;
            if (data_out_ready || memory_request_ready) extra++;
        end
        check("t6_late_ignored", extra, 0);
        m_reset();
        access(1'b0, 8'h00, 16'h0400, 1'b0, 16'h0, 0, rd, used);
        check("t6_miss", used, 1);
        check("t6_data", rd, 8'h5E);

        for (int n = 0; n < 200; n++) begin
            ra = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0)
                pulse_inv(16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 63)));
            ka = ($urandom_range(0, 1) == 0) ? ra
               : 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 63));
            access($urandom_range(0, 3) == 0, 8'($urandom), ra,
                   $urandom_range(0, 7) == 0, ka, $urandom_range(0, 2),
                   rd, used);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
